nap_main_fsm: RTL
=================

# nap_main_fsm

Parametrised main controller for the power-nap timer. It sequences start, auto/manual setting, sleep countdown, alarm, snooze and cancel. Nap duration is counted internally from a 1 Hz tick; there is no external sleep-complete input. The block adds bounded snooze, alarm auto-timeout and remaining-time/snooze-count outputs, and sits between the keypad/setting logic and the display/buzzer drivers.

## Interface
- TIME_W, 16: width of the seconds countdown and of napTime.
- SNOOZE_SEC, 300: snooze length in ticks. Must satisfy 1 ≤ SNOOZE_SEC < 2^TIME_W.
- MAX_SNOOZE, 3: maximum snoozes per nap. 0 disables snooze.
- ALARM_TIMEOUT, 60: ticks the alarm rings before auto-cancel. 0 means ring until a key is pressed.

Ports:
- clock, in, 1: system clock, rising edge.
- reset, in, 1: synchronous, active-high.
- tick, in, 1: one-cycle 1 Hz strobe.
- switch, in, 1: 0 selects auto setting, 1 selects manual setting.
- completeSetting, in, 1: setting done; napTime is valid in the same cycle.
- napTime, in, TIME_W: nap length in ticks.
- sharp, in, 1: cancel key, one-cycle pulse.
- snooze, in, 1: snooze key, one-cycle pulse.
- init, enAutoSetting, enManualSetting, enSleep, enAlarm, enSnooze, enCancel, out, 1 each: one-hot state enables.
- remaining, out, TIME_W: ticks left in SLEEP/SNOOZE.
- snoozeCount, out, clog2(MAX_SNOOZE+1) bits, minimum 1: snoozes used.
- timedOut, out, 1: last alarm ended by timeout.

## Operation
- States: START, AUTO_SET, MANUAL_SET, SLEEP, ALARM, SNOOZE, CANCEL.
- Enables are decoded from the registered state. Exactly one enable is high in every cycle.
- START (init):
  - Next state is AUTO_SET if switch=0, else MANUAL_SET.
  - On leaving START: timedOut←0, snoozeCount←0.
- AUTO_SET / MANUAL_SET: hold until completeSetting=1, then remaining←napTime.
  - If napTime=0, go to ALARM.
  - Otherwise go to SLEEP.
- SLEEP:
  - sharp=1 → CANCEL. sharp has priority; a coincident tick is not counted.
  - Else on tick, remaining←remaining−1.
  - If tick arrives with remaining=1 → ALARM, with remaining←0.
- ALARM: alarm tick timer is cleared on entry. Priority is sharp > snooze > timeout.
  - sharp → CANCEL.
  - snooze with snoozeCount<MAX_SNOOZE → SNOOZE, with remaining←SNOOZE_SEC and snoozeCount+1.
  - snooze with snoozeCount=MAX_SNOOZE is ignored; the block stays in ALARM.
  - If ALARM_TIMEOUT≠0 and a tick brings the timer to ALARM_TIMEOUT → CANCEL, with timedOut←1.
- SNOOZE: same countdown as SLEEP. Expiry → ALARM with a fresh alarm timer. sharp → CANCEL.
- CANCEL: lasts exactly one cycle, with remaining←0, then goes to START.
- Ticks in START, SET and CANCEL are ignored. snooze outside ALARM is ignored.
- Illegal state encoding → START on the next edge.

## Timing
- Reset values (asserted at the edge where reset=1): state=START, init=1, all other enables 0, remaining=0, snoozeCount=0, timedOut=0.
- Reset mid-operation (any state) returns to START at that edge. Counters are cleared.
- START → SET: 1 cycle.
- completeSetting sampled at edge k → enSleep=1 from cycle k+1.
- ALARM is entered at the edge that samples the napTime-th tick counted in SLEEP.
- Key-to-CANCEL latency is 1 edge. CANCEL → START is 1 edge.
- remaining updates on the same edge as the tick that decrements it.

## Test plan
- Auto nap: reset, then switch=0, napTime=3, completeSetting pulse, then 3 ticks → enSleep while remaining goes 3,2,1. enAlarm after the 3rd tick with remaining=0.
- Manual cancel: switch=1, napTime=10, 2 ticks, then sharp together with a tick → remaining=8. enCancel for 1 cycle, then init=1.
- Snooze limit, with MAX_SNOOZE=2 and SNOOZE_SEC=2: reach ALARM, then snooze → enSnooze with remaining=2 and snoozeCount=1. Repeat → snoozeCount=2. Third snooze → stays enAlarm.
- Timeout, with ALARM_TIMEOUT=4: in ALARM give 4 ticks and no keys → CANCEL with timedOut=1. timedOut clears when START is exited.
- Zero nap: completeSetting with napTime=0 → enAlarm the next cycle.
- Reset mid-SNOOZE: assert reset → init=1 and remaining=0, snoozeCount=0, timedOut=0.

Source files
------------

// File: rtl/nap_main_fsm_if.sv
// Signal bundle between the nap controller and its keypad/setting and display/buzzer neighbours.
// The slave side is the controller; the master side drives keys, ticks and the setting result.
interface nap_main_fsm_if #(
    parameter int unsigned TIME_W = 16,
    parameter int unsigned CNT_W  = 2
) ();
    logic              tick;
    logic              switch;
    logic              completeSetting;
    logic [TIME_W-1:0] napTime;
    logic              sharp;
    logic              snooze;

    logic              init;
    logic              enAutoSetting;
    logic              enManualSetting;
    logic              enSleep;
    logic              enAlarm;
    logic              enSnooze;
    logic              enCancel;
    logic [TIME_W-1:0] remaining;
    logic [CNT_W-1:0]  snoozeCount;
    logic              timedOut;

    modport master (
        output tick, switch, completeSetting, napTime, sharp, snooze,
        input  init, enAutoSetting, enManualSetting, enSleep, enAlarm, enSnooze, enCancel,
        input  remaining, snoozeCount, timedOut
    );

    modport slave (
        input  tick, switch, completeSetting, napTime, sharp, snooze,
        output init, enAutoSetting, enManualSetting, enSleep, enAlarm, enSnooze, enCancel,
        output remaining, snoozeCount, timedOut
    );
endinterface

// File: rtl/nap_main_fsm.sv
// Power-nap main controller: setting, tick-driven sleep countdown, alarm with bounded snooze,
// alarm auto-timeout and cancel. The bus interface must be sized with matching TIME_W/CNT_W.
module nap_main_fsm #(
    parameter int unsigned TIME_W        = 16,
    parameter int unsigned SNOOZE_SEC    = 300,
    parameter int unsigned MAX_SNOOZE    = 3,
    parameter int unsigned ALARM_TIMEOUT = 60
) (
    input logic            clock,
    input logic            reset,
    nap_main_fsm_if.slave  bus
);
    localparam int unsigned CNT_W = (MAX_SNOOZE == 0) ? 1 : $clog2(MAX_SNOOZE + 1);
    localparam int unsigned TMR_W = (ALARM_TIMEOUT < 2) ? 1 : $clog2(ALARM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StStart, StAutoSet, StManualSet, StSleep, StAlarm, StSnooze, StCancel
    } stateT;

    stateT             stateQ, stateD;
    logic [TIME_W-1:0] remainingQ, remainingD;
    logic [CNT_W-1:0]  snoozeCountQ, snoozeCountD;
    logic              timedOutQ, timedOutD;
    logic [TMR_W-1:0]  alarmTimerQ, alarmTimerD;

    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ       <= StStart;
            remainingQ   <= '0;
            snoozeCountQ <= '0;
            timedOutQ    <= 1'b0;
            alarmTimerQ  <= '0;
        end else begin
            stateQ       <= stateD;
            remainingQ   <= remainingD;
            snoozeCountQ <= snoozeCountD;
            timedOutQ    <= timedOutD;
            alarmTimerQ  <= alarmTimerD;
        end
    end

    always_comb begin
        stateD       = stateQ;
        remainingD   = remainingQ;
        snoozeCountD = snoozeCountQ;
        timedOutD    = timedOutQ;
        // Timer is held only while ringing, so every ALARM entry starts from zero.
        alarmTimerD  = '0;
        case (stateQ)
            StStart: begin
                stateD       = bus.switch ? StManualSet : StAutoSet;
                timedOutD    = 1'b0;
                snoozeCountD = '0;
            end
            StAutoSet, StManualSet: begin
                if (bus.completeSetting) begin
                    remainingD = bus.napTime;
                    stateD     = (bus.napTime == '0) ? StAlarm : StSleep;
                end
            end
            StSleep, StSnooze: begin
                if (bus.sharp) begin
                    stateD = StCancel;
                end else if (bus.tick) begin
                    remainingD = remainingQ - TIME_W'(1);
                    if (remainingQ == TIME_W'(1)) stateD = StAlarm;
                end
            end
            StAlarm: begin
                alarmTimerD = alarmTimerQ;
                if (bus.sharp) begin
                    stateD = StCancel;
                end else if (bus.snooze && (snoozeCountQ < CNT_W'(MAX_SNOOZE))) begin
                    stateD       = StSnooze;
                    remainingD   = TIME_W'(SNOOZE_SEC);
                    snoozeCountD = snoozeCountQ + CNT_W'(1);
                end else if ((ALARM_TIMEOUT != 0) && bus.tick) begin
                    alarmTimerD = alarmTimerQ + TMR_W'(1);
                    if (alarmTimerD == TMR_W'(ALARM_TIMEOUT)) begin
                        stateD    = StCancel;
                        timedOutD = 1'b1;
                    end
                end
            end
            StCancel: begin
                remainingD = '0;
                stateD     = StStart;
            end
            default: stateD = StStart;
        endcase
    end

    always_comb begin
        bus.init            = 1'b0;
        bus.enAutoSetting   = 1'b0;
        bus.enManualSetting = 1'b0;
        bus.enSleep         = 1'b0;
        bus.enAlarm         = 1'b0;
        bus.enSnooze        = 1'b0;
        bus.enCancel        = 1'b0;
        case (stateQ)
            StAutoSet:   bus.enAutoSetting   = 1'b1;
            StManualSet: bus.enManualSetting = 1'b1;
            StSleep:     bus.enSleep         = 1'b1;
            StAlarm:     bus.enAlarm         = 1'b1;
            StSnooze:    bus.enSnooze        = 1'b1;
            StCancel:    bus.enCancel        = 1'b1;
            default:     bus.init            = 1'b1;
        endcase
        bus.remaining   = remainingQ;
        bus.snoozeCount = snoozeCountQ;
        bus.timedOut    = timedOutQ;
    end
endmodule
